// File: rtl/cpu_step_console_if.sv
// Observation bus between the single-cycle RIJ CPU and its debug console:
// the CPU presents its visible state, the console returns the step clock.
interface cpu_step_console_if;
  logic [31:0] F;
  logic [31:0] M_R_Data;
  logic [31:0] PC;
  logic        ZF;
  logic        OF;
  logic        cpu_clk;

  // CPU side drives its state and consumes the step clock
  modport master (output F, M_R_Data, PC, ZF, OF, input cpu_clk);
  // Console side samples the CPU state and generates the step clock
  modport slave  (input F, M_R_Data, PC, ZF, OF, output cpu_clk);
endinterface

// File: rtl/cpu_step_console.sv
// Debug console for the RIJ CPU: debounced single-step clock generation plus
// post-step snapshots shown on an 8-digit multiplexed 7-segment display.
module cpu_step_console #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 50,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic                step_btn,
  input  logic [1:0]          sel,
  cpu_step_console_if.slave   cpu,
  output logic                busy,
  output logic [15:0]         step_count,
  output logic [7:0]          an,
  output logic [7:0]          seg
);

  localparam int CNT_MAX  = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SCAN_W   = $clog2(SCAN_CYCLES + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]        sync_q;
  logic              s;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              cpu_clk_q;
  logic [31:0]       snap_f;
  logic [31:0]       snap_mem;
  logic [31:0]       snap_pc;
  logic [31:0]       snap_flags;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit_idx;
  logic [2:0]        digit_next;
  logic              scan_wrap;
  logic [31:0]       disp_val;
  logic [3:0]        nibble;

  assign s           = sync_q[1];
  assign busy        = (state != IDLE);
  assign cpu.cpu_clk = cpu_clk_q;

  // One counter serves press debounce, pulse width and release debounce,
  // since only one of them is ever active in a given state.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      state      <= IDLE;
      cnt        <= '0;
      cpu_clk_q  <= 1'b0;
      step_count <= '0;
      // NOTE: snapshots are a handful of registers, not a RAM, so resetting
      // them is cheap and keeps the display deterministic after reset.
      snap_f     <= '0;
      snap_mem   <= '0;
      snap_pc    <= '0;
      snap_flags <= '0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
      case (state)
        IDLE: begin
          if (!s) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state      <= PULSE;
            cnt        <= '0;
            cpu_clk_q  <= 1'b1;
            step_count <= step_count + 16'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PULSE: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            // The CPU has just committed this step; freeze what it shows.
            cpu_clk_q  <= 1'b0;
            state      <= RELEASE;
            cnt        <= '0;
            snap_f     <= cpu.F;
            snap_mem   <= cpu.M_R_Data;
            snap_pc    <= cpu.PC;
            snap_flags <= {30'b0, cpu.ZF, cpu.OF};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (s) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          cpu_clk_q <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));
  assign digit_next = scan_wrap ? digit_idx + 3'd1 : digit_idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    disp_val = snap_f;
    case (sel)
      2'b01:   disp_val = snap_mem;
      2'b10:   disp_val = snap_pc;
      2'b11:   disp_val = snap_flags;
      default: disp_val = snap_f;
    endcase
  end

  assign nibble = disp_val[{digit_next, 2'b00} +: 4];

  // an/seg are driven from the upcoming digit index so they move together
  // with it rather than trailing by a cycle.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      an        <= 8'hFE;
      seg       <= 8'hC0;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit_idx <= digit_next;
      an        <= ~(8'h01 << digit_next);
      seg       <= hex7(nibble);
    end
  end

endmodule

// File: tb/tb_cpu_step_console.sv
// Scoreboard bench for cpu_step_console: stimulus queues expected step pulses
// and display digits, independent monitors pop and compare them.
module tb_cpu_step_console;
  localparam int DEB  = 4;
  localparam int PUL  = 3;
  localparam int SCAN = 2;

  logic        clk_100MHz = 1'b0;
  logic        rst        = 1'b1;
  logic        step_btn   = 1'b0;
  logic [1:0]  sel        = 2'b00;
  logic        busy;
  logic [15:0] step_count;
  logic [7:0]  an;
  logic [7:0]  seg;

  cpu_step_console_if cpu ();

  cpu_step_console #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst       (rst),
    .step_btn  (step_btn),
    .sel       (sel),
    .cpu       (cpu),
    .busy      (busy),
    .step_count(step_count),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  typedef struct {
    int          rise_cyc;
    logic [15:0] count;
    int          width;
  } pulse_t;

  typedef struct {
    string       name;
    logic [7:0]  an;
    logic [7:0]  seg;
  } disp_t;

  pulse_t pulse_q[$];
  disp_t  disp_q[$];
  int     vectors     = 0;
  int     miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
  endtask

  // Pulse monitor: each cpu_clk pulse must match the next queued expectation.
  logic   prev_clk = 1'b0;
  bit     pulse_active = 1'b0;
  int     width = 0;
  pulse_t cur;
  always @(negedge clk_100MHz) begin
    if (cpu.cpu_clk && !prev_clk) begin
      width = 1;
      if (pulse_q.size() == 0) begin
        fail_event("unexpected cpu_clk pulse");
        pulse_active = 1'b0;
      end else begin
        cur = pulse_q.pop_front();
        pulse_active = 1'b1;
        check("pulse rise cycle", cyc, cur.rise_cyc);
        check("step_count at rise", {16'b0, step_count}, {16'b0, cur.count});
      end
    end else if (cpu.cpu_clk) begin
      width++;
    end else if (prev_clk && pulse_active) begin
      check("pulse width", width, cur.width);
      pulse_active = 1'b0;
    end
    prev_clk = cpu.cpu_clk;
  end

  // Display monitor: waits for the requested digit to be enabled, then checks seg.
  int disp_wait = 0;
  always @(negedge clk_100MHz) begin
    if (disp_q.size() > 0) begin
      if (an === disp_q[0].an) begin
        check(disp_q[0].name, {24'b0, seg}, {24'b0, disp_q[0].seg});
        void'(disp_q.pop_front());
        disp_wait = 0;
      end else if (++disp_wait > 40) begin
        fail_event(disp_q[0].name);
        void'(disp_q.pop_front());
        disp_wait = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic expect_digit(input string name, input int idx, input logic [7:0] s);
    disp_t d;
    d.name = name;
    d.an   = ~(8'h01 << idx);
    d.seg  = s;
    disp_q.push_back(d);
  endtask

  task automatic expect_pulse(input int rise, input logic [15:0] count, input int w);
    pulse_t p;
    p.rise_cyc = rise;
    p.count    = count;
    p.width    = w;
    pulse_q.push_back(p);
  endtask

  task automatic drain();
    int t = 0;
    while ((disp_q.size() > 0 || pulse_q.size() > 0 || pulse_active) && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) fail_event("scoreboard drain");
  endtask

  // Clean press: rise lands 6 edges after the button goes high
  // (2 sync flops + 4 debounce samples).
  task automatic press(input int hold, input logic [15:0] count);
    step_btn = 1'b1;
    expect_pulse(cyc + 6, count, PUL);
    tick(hold);
    step_btn = 1'b0;
    tick(8);
  endtask

  initial begin
    int n0;
    cpu.F = '0; cpu.M_R_Data = '0; cpu.PC = '0; cpu.ZF = 1'b0; cpu.OF = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset cpu_clk", {31'b0, cpu.cpu_clk}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset step_count", {16'b0, step_count}, 32'd0);
    check("reset an", {24'b0, an}, 32'hFE);
    check("reset seg", {24'b0, seg}, 32'hC0);
    tick(15);
    check("scan digit 7 before wrap", {24'b0, an}, 32'h7F);
    tick(1);
    check("scan wrapped to digit 0", {24'b0, an}, 32'hFE);

    // Bounce rejection: two 3-cycle highs never reach 4 stable samples
    step_btn = 1'b1; tick(3);
    step_btn = 1'b0; tick(1);
    step_btn = 1'b1; tick(3);
    step_btn = 1'b0; tick(10);
    check("bounce step_count", {16'b0, step_count}, 32'd0);
    check("bounce busy", {31'b0, busy}, 32'd0);

    // Clean press held 30 cycles, with F snapshotted at the end of the pulse
    cpu.F = 32'h1234ABCD;
    sel = 2'b00;
    n0 = cyc;
    step_btn = 1'b1;
    expect_pulse(n0 + 6, 16'd1, PUL);
    tick(6);
    check("busy at pulse start", {31'b0, busy}, 32'd1);
    tick(5);
    cpu.F = 32'h0;
    tick(2);
    expect_digit("F digit0", 0, 8'hA1);
    expect_digit("F digit1", 1, 8'hC6);
    expect_digit("F digit2", 2, 8'h83);
    expect_digit("F digit3", 3, 8'h88);
    expect_digit("F digit4", 4, 8'h99);
    expect_digit("F digit7", 7, 8'hF9);
    drain();
    while (cyc < n0 + 30) tick(1);
    step_btn = 1'b0;
    tick(5);
    check("busy before release debounce", {31'b0, busy}, 32'd1);
    tick(1);
    check("busy after release debounce", {31'b0, busy}, 32'd0);
    check("step_count after press", {16'b0, step_count}, 32'd1);
    expect_digit("F held in IDLE", 0, 8'hA1);
    drain();

    // Source select
    cpu.F = 32'h89; cpu.M_R_Data = 32'hE5; cpu.PC = 32'h4;
    cpu.ZF = 1'b1;  cpu.OF = 1'b0;
    press(10, 16'd2);
    sel = 2'b11; tick(2);
    expect_digit("flags digit0", 0, 8'hA4);
    expect_digit("flags digit1", 1, 8'hC0);
    expect_digit("flags digit7", 7, 8'hC0);
    drain();
    sel = 2'b10; tick(2);
    expect_digit("PC digit0", 0, 8'h99);
    expect_digit("PC digit1", 1, 8'hC0);
    drain();
    sel = 2'b01; tick(2);
    expect_digit("M_R_Data digit0", 0, 8'h92);
    expect_digit("M_R_Data digit1", 1, 8'h86);
    drain();
    sel = 2'b00; tick(2);
    expect_digit("F2 digit0", 0, 8'h90);
    expect_digit("F2 digit1", 1, 8'h80);
    drain();

    // Reset during the second high cycle of the step pulse
    cpu.F = 32'hFFFFFFFF;
    step_btn = 1'b1;
    expect_pulse(cyc + 6, 16'd3, 1);
    tick(7);
    rst = 1'b1;
    #1;
    check("mid-pulse reset cpu_clk", {31'b0, cpu.cpu_clk}, 32'd0);
    check("mid-pulse reset step_count", {16'b0, step_count}, 32'd0);
    check("mid-pulse reset busy", {31'b0, busy}, 32'd0);
    step_btn = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    expect_digit("F snapshot cleared", 0, 8'hC0);
    expect_digit("F snapshot cleared d1", 1, 8'hC0);
    drain();
    sel = 2'b01; tick(2);
    expect_digit("M_R_Data snapshot cleared", 0, 8'hC0);
    drain();
    sel = 2'b11; tick(2);
    expect_digit("flags snapshot cleared", 0, 8'hC0);
    drain();
    sel = 2'b00;
    cpu.F = 32'h7;
    press(10, 16'd1);
    check("step_count after reset press", {16'b0, step_count}, 32'd1);
    check("busy after reset press", {31'b0, busy}, 32'd0);
    tick(2);
    expect_digit("F after reset press", 0, 8'hF8);
    drain();
    check("pulse queue empty", pulse_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
